bus_cycle_sequencer: RTL
========================

// Module: bus_cycle_sequencer
// PURPOSE
//  Sequences 8085-style multiplexed address/data bus cycles (T1/T2/TW/T3) for two requesters: instruction fetch and data load/store.
//  Arbitrates the requesters round-robin, then drives ALE, adbd, the address and data buses, RD_n/WR_n, and honours READY wait states.
//  Sits between the CPU core and Bus_Conductor: ALE, adbd, addr_bus and Data_Bus_Out feed the conductor, and Data_Bus_In returns from it.
// PARAMETERS
//  MAX_WAIT  15  max TW cycles before timeout; 0 = READY ignored, no TW inserted
// PORTS
//  clk           in   1  system clock, rising edge
//  rst_n         in   1  asynchronous active-low reset
//  req_fetch     in   1  fetch request (read only), level, held until acc_fetch
//  addr_fetch    in   8  fetch address
//  acc_fetch     out  1  fetch accepted this cycle (combinational, IDLE only)
//  done_fetch    out  1  one-cycle pulse; rdata valid
//  req_data      in   1  data request, level, held until acc_data
//  we_data       in   1  1 = write, 0 = read
//  addr_data     in   8  data address
//  wdata         in   8  write data
//  acc_data      out  1  data accepted this cycle (combinational, IDLE only)
//  done_data     out  1  one-cycle pulse; rdata valid if read
//  rdata         out  8  read data, held until next read completes
//  bus_err       out  1  pulses with done_x when the cycle timed out
//  busy          out  1  1 in every state except IDLE
//  READY         in   1  slave ready, sampled on rising edge in T2/TW
//  ALE           out  1  to Bus_Conductor
//  adbd          out  1  to Bus_Conductor, drive Data_Bus_Out onto bus
//  addr_bus      out  8  to Bus_Conductor
//  Data_Bus_Out  out  8  to Bus_Conductor
//  Data_Bus_In   in   8  from Bus_Conductor
//  RD_n          out  1  active-low read strobe
//  WR_n          out  1  active-low write strobe
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, ALE=0, adbd=0, RD_n=1, WR_n=1, addr_bus=0, Data_Bus_Out=0, rdata=0, done_*=0,
//    bus_err=0, busy=0, wait counter=0, last_grant=DATA (fetch wins first contention). Reset mid-cycle drops the transaction, no done.
//  - All bus-side outputs are registered (decoded from next state); no glitches. ALE and adbd are never 1 together.
//  - IDLE: if any req, grant one. Only one req: grant it. Both: grant the one not in last_grant. Assert acc_x in the same cycle.
//    On that edge: latch addr, we (fetch forces we=0), wdata and owner; update last_grant; go T1.
//  - T1: ALE=1, addr_bus=latched addr, RD_n=WR_n=1, adbd=0. Next state is T2.
//  - T2: ALE=0. Read: RD_n=0. Write: WR_n=0, adbd=1, Data_Bus_Out=wdata.
//    At edge: READY=1 or MAX_WAIT=0 -> T3; else -> TW with wait counter=1.
//  - TW: strobes/adbd held as T2. READY=1 -> T3. Else if counter==MAX_WAIT -> T3 with timeout flag set. Else counter++.
//  - T3: strobes still held. At the edge leaving T3: RD_n/WR_n->1, adbd->0. Read: rdata<=Data_Bus_In, or 8'hFF on timeout.
//    done_<owner><=1 and bus_err<=timeout for exactly one cycle. Next state is IDLE.
//  - Latency, zero waits: accept cycle n; T1 n+1; T2 n+2; T3 n+3; done and rdata in n+4. Each TW adds 1 cycle.
//    Back-to-back: the next acc can occur in cycle n+4, which is the done cycle.
//  - req seen outside IDLE is ignored (no acc). Requesters must drop or change req after acc.
//  - Address/data fields are don't-care except in the accept cycle.
// STRUCTURE
//  - Shared package bus_ctrl_pkg: state encoding (IDLE,T1,T2,TW,T3) and owner IDs (OWN_FETCH=0, OWN_DATA=1).
//  - Sub-module rr_arbiter2: 2-way round-robin with last_grant register and an advance-enable from IDLE.
//    The FSM, wait counter ($clog2(MAX_WAIT+1) bits) and output registers stay in the top module.
// TESTING
//  1. Reset held low, toggle clk -> all outputs at reset values; rst_n rise -> IDLE, busy=0.
//  2. req_fetch, addr 8'h3C, READY=1, Data_Bus_In=8'hA5 -> acc_fetch in the cycle, ALE=1/addr_bus=3C next cycle,
//     RD_n=0 two cycles, done_fetch and rdata=A5 4 cycles after acc.
//  3. Data write addr 8'h80, wdata 8'h5A, READY low 3 cycles -> 3 TW cycles, adbd=1/Data_Bus_Out=5A/WR_n=0 for 5 cycles,
//     done_data at acc+7, no RD_n.
//  4. req_fetch and req_data together held high, 4 transactions -> grants alternate fetch, data, fetch, data; ALE & adbd never both 1.
//  5. READY stuck low, MAX_WAIT=15, read -> 15 TW, done and bus_err pulse together, rdata=FF; next request runs normally.
//  6. rst_n low during TW of a write -> WR_n=1, adbd=0 immediately, no done_data; after release a new req completes normally.

Source files
------------

// File: rtl/bus_ctrl_pkg.sv
// Shared types for the 8085-style bus cycle sequencer: cycle states and requester IDs.
package bus_ctrl_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // States in which RD_n/WR_n (and adbd for writes) are active.
    function automatic logic strobe_phase(input state_e s);
        return (s == ST_T2) || (s == ST_TW) || (s == ST_T3);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the winner of a contention is the requester that did not win last.
module rr_arbiter2
    import bus_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_fetch_i,
    input  logic req_data_i,
    input  logic adv_en_i,
    output logic gnt_fetch_c,
    output logic gnt_data_c
);

    owner_e last_q, last_d;

    always_comb begin
        gnt_fetch_c = 1'b0;
        gnt_data_c  = 1'b0;
        last_d      = last_q;
        if (adv_en_i) begin
            if (req_fetch_i && req_data_i) begin
                if (last_q == OWN_DATA) gnt_fetch_c = 1'b1;
                else                    gnt_data_c  = 1'b1;
            end else if (req_fetch_i) begin
                gnt_fetch_c = 1'b1;
            end else if (req_data_i) begin
                gnt_data_c = 1'b1;
            end
            if (gnt_fetch_c) last_d = OWN_FETCH;
            if (gnt_data_c)  last_d = OWN_DATA;
        end
    end

    // Reset to DATA so fetch wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= OWN_DATA;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Runs T1/T2/TW/T3 multiplexed bus cycles for fetch and data requesters; all bus-side
// outputs are registered and decoded from the next state.
module bus_cycle_sequencer
    import bus_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_fetch,
    input  logic [ADDR_W-1:0] addr_fetch,
    output logic              acc_fetch,
    output logic              done_fetch,
    input  logic              req_data,
    input  logic              we_data,
    input  logic [ADDR_W-1:0] addr_data,
    input  logic [DATA_W-1:0] wdata,
    output logic              acc_data,
    output logic              done_data,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_err,
    output logic              busy,
    input  logic              READY,
    output logic              ALE,
    output logic              adbd,
    output logic [ADDR_W-1:0] addr_bus,
    output logic [DATA_W-1:0] Data_Bus_Out,
    input  logic [DATA_W-1:0] Data_Bus_In,
    output logic              RD_n,
    output logic              WR_n
);

    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              ale_q, ale_d, adbd_q, adbd_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic [ADDR_W-1:0] addr_bus_q, addr_bus_d;
    logic [DATA_W-1:0] dbo_q, dbo_d, rdata_q, rdata_d;
    logic              done_fetch_q, done_fetch_d, done_data_q, done_data_d;
    logic              bus_err_q, bus_err_d, busy_q, busy_d;
    logic              gnt_fetch_c, gnt_data_c;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_fetch_i (req_fetch),
        .req_data_i  (req_data),
        .adv_en_i    (state_q == ST_IDLE),
        .gnt_fetch_c (gnt_fetch_c),
        .gnt_data_c  (gnt_data_c)
    );

    assign acc_fetch = gnt_fetch_c;
    assign acc_data  = gnt_data_c;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                tmo_d = 1'b0;
                if (gnt_fetch_c) begin
                    owner_d = OWN_FETCH;
                    we_d    = 1'b0;
                    addr_d  = addr_fetch;
                    state_d = ST_T1;
                end else if (gnt_data_c) begin
                    owner_d = OWN_DATA;
                    we_d    = we_data;
                    addr_d  = addr_data;
                    wdata_d = wdata;
                    state_d = ST_T1;
                end
            end
            ST_T1: state_d = ST_T2;
            ST_T2: begin
                if (READY || (MAX_WAIT == 0)) begin
                    state_d = ST_T3;
                end else begin
                    state_d = ST_TW;
                    cnt_d   = CNT_W'(1);
                end
            end
            // Timeout completes the cycle with the error flag instead of waiting forever.
            ST_TW: begin
                if (READY) begin
                    state_d = ST_T3;
                end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
                    state_d = ST_T3;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_T3:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ale_d        = (state_d == ST_T1);
        adbd_d       = strobe_phase(state_d) && we_d;
        rd_n_d       = !(strobe_phase(state_d) && !we_d);
        wr_n_d       = !(strobe_phase(state_d) && we_d);
        addr_bus_d   = (state_d == ST_T1) ? addr_d : addr_bus_q;
        dbo_d        = ((state_d == ST_T2) && we_d) ? wdata_d : dbo_q;
        busy_d       = (state_d != ST_IDLE);
        rdata_d      = rdata_q;
        done_fetch_d = 1'b0;
        done_data_d  = 1'b0;
        bus_err_d    = 1'b0;
        if (state_q == ST_T3) begin
            done_fetch_d = (owner_q == OWN_FETCH);
            done_data_d  = (owner_q == OWN_DATA);
            bus_err_d    = tmo_q;
            if (!we_q) rdata_d = tmo_q ? 8'hFF : Data_Bus_In;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tmo_q        <= 1'b0;
            owner_q      <= OWN_FETCH;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ale_q        <= 1'b0;
            adbd_q       <= 1'b0;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            addr_bus_q   <= '0;
            dbo_q        <= '0;
            rdata_q      <= '0;
            done_fetch_q <= 1'b0;
            done_data_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ale_q        <= ale_d;
            adbd_q       <= adbd_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            addr_bus_q   <= addr_bus_d;
            dbo_q        <= dbo_d;
            rdata_q      <= rdata_d;
            done_fetch_q <= done_fetch_d;
            done_data_q  <= done_data_d;
            bus_err_q    <= bus_err_d;
            busy_q       <= busy_d;
        end
    end

    assign ALE          = ale_q;
    assign adbd         = adbd_q;
    assign RD_n         = rd_n_q;
    assign WR_n         = wr_n_q;
    assign addr_bus     = addr_bus_q;
    assign Data_Bus_Out = dbo_q;
    assign rdata        = rdata_q;
    assign done_fetch   = done_fetch_q;
    assign done_data    = done_data_q;
    assign bus_err      = bus_err_q;
    assign busy         = busy_q;

endmodule
